// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first into a ccff chain, with an optional verify re-shift pass.
// Latency: first bit on ccff_head one cycle after word acceptance; word_ready held low while bits remain buffered.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 10,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_bit_idx
);

    localparam int               BW    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               verify_q, verify_d;
    logic [WORD_W-1:0]  buf_q, buf_d;
    logic [BW-1:0]      buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               head_q, head_d;
    logic               clk_en_q, clk_en_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   err_idx_q, err_idx_d;

    logic               busy_w;
    logic               shift_w;
    logic               ready_w;
    logic               last_w;
    logic [31:0]        rem32;
    logic [31:0]        n32;

    assign busy_w  = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign shift_w = (buf_cnt_q != '0);
    assign ready_w = busy_w && !shift_w && (bit_cnt_q < LEN_C);
    assign last_w  = shift_w && ((bit_cnt_q + CNT_W'(1)) == LEN_C);
    assign rem32   = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
    // The final word of a pass only carries the bits still owed to the chain.
    assign n32     = (rem32 < 32'(WORD_W)) ? rem32 : 32'(WORD_W);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q   <= S_IDLE;
            verify_q  <= 1'b0;
            buf_q     <= '0;
            buf_cnt_q <= '0;
            bit_cnt_q <= '0;
            head_q    <= 1'b0;
            clk_en_q  <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            verify_q  <= verify_d;
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            head_q    <= head_d;
            clk_en_q  <= clk_en_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        verify_d  = verify_q;
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        bit_cnt_d = bit_cnt_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;

        if (shift_w) begin
            buf_d     = buf_q >> 1;
            buf_cnt_d = buf_cnt_q - BW'(1);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if ((state_q == S_VERIFY) && (ccff_tail != head_q) && !error_q) begin
                error_d   = 1'b1;
                err_idx_d = bit_cnt_q;
            end
        end else if (ready_w && word_valid) begin
            for (int i = 0; i < WORD_W; i++) begin
                buf_d[i] = word_data[i] & (32'(i) < n32);
            end
            buf_cnt_d = BW'(n32);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    verify_d  = verify_en;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    bit_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (last_w) begin
                    state_d   = verify_q ? S_VERIFY : S_DONE;
                    bit_cnt_d = '0;
                end
            end
            S_VERIFY: begin
                if (last_w) begin
                    state_d   = S_DONE;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            error_d   = 1'b0;
            err_idx_d = '0;
            buf_d     = '0;
            buf_cnt_d = '0;
            bit_cnt_d = '0;
        end

        // Head and enable are registered from the same next-state so they move together.
        clk_en_d = (buf_cnt_d != '0);
        head_d   = clk_en_d & buf_d[0];
    end

    assign word_ready   = ready_w;
    assign ccff_head    = head_q;
    assign chain_clk_en = clk_en_q;
    assign busy         = busy_w;
    assign done         = (state_q == S_DONE);
    assign error        = error_q;
    assign err_bit_idx  = err_idx_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 10-stage chain model on the gated programming clock.
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       start;
    logic       verify_en;
    logic       abort;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       ccff_head;
    logic       chain_clk_en;
    logic       ccff_tail;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] err_bit_idx;

    int          total = 0;
    int          bad = 0;
    int          pulse_cnt = 0;
    int          acc_cnt = 0;
    int          viol_cnt = 0;
    int          run_base = 0;
    logic        fault_en = 1'b0;
    logic [63:0] head_log = '0;
    logic [9:0]  chain = '0;

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8), .CNT_W(8)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .verify_en    (verify_en),
        .abort        (abort),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .ccff_head    (ccff_head),
        .chain_clk_en (chain_clk_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_bit_idx  (err_bit_idx)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: shifts only on edges the external ICG lets through.
    always @(posedge prog_clk) begin
        if (chain_clk_en) begin
            chain                   <= {chain[8:0], ccff_head};
            head_log[6'(pulse_cnt)] <= ccff_head;
            pulse_cnt               <= pulse_cnt + 1;
        end
        if (word_valid && word_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge prog_clk) begin
        if (word_ready && chain_clk_en) viol_cnt <= viol_cnt + 1;
    end

    // Optional read fault: stream bits 6 and 8 come back as 0 during the verify pass.
    assign ccff_tail = chain[9] & ~(fault_en &&
                       (((pulse_cnt - run_base) == 16) || ((pulse_cnt - run_base) == 18)));

    task automatic start_seq(input logic v);
        start = 1'b1;
        verify_en = v;
        @(negedge prog_clk);
        start = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        int t = 0;
        word_data = d;
        word_valid = 1'b1;
        while (!word_ready && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        if (t >= 200) begin
            total++; bad++;
            $display("FAIL send_word_timeout data=%h ready never seen", d);
        end
        @(negedge prog_clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done && t < 400) begin
            @(negedge prog_clk);
            t++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout got=%b want=1", name, done);
        end
    endtask

    function automatic logic [9:0] seq_from(input int base);
        logic [9:0] s;
        for (int i = 0; i < 10; i++) s[i] = head_log[6'(base + i)];
        return s;
    endfunction

    task automatic test_reset;
        prog_reset_n = 1'b0;
        #3;
        total++;
        if ({word_ready, ccff_head, chain_clk_en, busy, done, error} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {word_ready, ccff_head, chain_clk_en, busy, done, error});
        end
        total++;
        if (err_bit_idx !== 8'd0) begin
            bad++; $display("FAIL reset_err_idx got=%0d want=0", err_bit_idx);
        end
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        total++;
        if ({busy, word_ready, done} !== 3'b000) begin
            bad++; $display("FAIL reset_idle got=%b want=000", {busy, word_ready, done});
        end
    endtask

    task automatic test_load_only;
        int base = pulse_cnt;
        int abase = acc_cnt;
        logic [9:0] s;
        start_seq(1'b0);
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++; $display("FAIL load_busy got=%b want=10", {busy, done});
        end
        send_word(8'hA5);
        send_word(8'h03);
        wait_done("load");
        total++;
        if (pulse_cnt - base !== 10) begin
            bad++; $display("FAIL load_pulses got=%0d want=10", pulse_cnt - base);
        end
        s = seq_from(base);
        total++;
        if (s !== 10'h3A5) begin
            bad++; $display("FAIL load_head_seq got=%h want=3a5", s);
        end
        total++;
        if ({done, busy, error} !== 3'b100) begin
            bad++; $display("FAIL load_status got=%b want=100", {done, busy, error});
        end
        total++;
        if (acc_cnt - abase !== 2) begin
            bad++; $display("FAIL load_words got=%0d want=2", acc_cnt - abase);
        end
        repeat (3) @(negedge prog_clk);
        total++;
        if ({done, chain_clk_en, ccff_head} !== 3'b100) begin
            bad++; $display("FAIL load_done_held got=%b want=100", {done, chain_clk_en, ccff_head});
        end
    endtask

    task automatic test_verify_ok;
        int base = pulse_cnt;
        start_seq(1'b1);
        send_word(8'hA5);
        start_seq(1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL verify_start_ignored got=%b want=1", busy);
        end
        send_word(8'h03);
        send_word(8'hA5);
        send_word(8'h03);
        wait_done("verify");
        total++;
        if (pulse_cnt - base !== 20) begin
            bad++; $display("FAIL verify_pulses got=%0d want=20", pulse_cnt - base);
        end
        total++;
        if ({error, err_bit_idx} !== 9'd0) begin
            bad++; $display("FAIL verify_no_error got=%b/%0d want=0/0", error, err_bit_idx);
        end
    endtask

    task automatic test_verify_fault;
        int base = pulse_cnt;
        run_base = pulse_cnt;
        fault_en = 1'b1;
        start_seq(1'b1);
        send_word(8'hE5);
        send_word(8'h03);
        send_word(8'hE5);
        send_word(8'h03);
        wait_done("fault");
        fault_en = 1'b0;
        total++;
        if (pulse_cnt - base !== 20) begin
            bad++; $display("FAIL fault_pulses got=%0d want=20", pulse_cnt - base);
        end
        total++;
        if (error !== 1'b1) begin
            bad++; $display("FAIL fault_error got=%b want=1", error);
        end
        total++;
        if (err_bit_idx !== 8'd6) begin
            bad++; $display("FAIL fault_err_idx got=%0d want=6", err_bit_idx);
        end
        total++;
        if (seq_from(base) !== 10'h3E5) begin
            bad++; $display("FAIL fault_head_seq got=%h want=3e5", seq_from(base));
        end
    endtask

    task automatic test_restart;
        start_seq(1'b1);
        total++;
        if ({error, err_bit_idx, done, busy} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL restart_clear got=err%b idx%0d done%b busy%b want=err0 idx0 done0 busy1",
                            error, err_bit_idx, done, busy);
        end
        send_word(8'hA5);
        send_word(8'h03);
        send_word(8'hA5);
        send_word(8'h03);
        wait_done("restart");
        total++;
        if (error !== 1'b0) begin
            bad++; $display("FAIL restart_error got=%b want=0", error);
        end
    endtask

    task automatic test_backpressure;
        int base = pulse_cnt;
        int abase = acc_cnt;
        int vbase = viol_cnt;
        int t = 0;
        start_seq(1'b0);
        word_valid = 1'b1;
        word_data = 8'hA5;
        while (!word_ready && t < 50) begin @(negedge prog_clk); t++; end
        @(negedge prog_clk);
        word_data = 8'hFF;
        @(negedge prog_clk);
        while (!word_ready && t < 50) begin @(negedge prog_clk); t++; end
        @(negedge prog_clk);
        wait_done("bp");
        word_valid = 1'b0;
        total++;
        if (viol_cnt - vbase !== 0) begin
            bad++; $display("FAIL bp_ready_while_shifting got=%0d want=0", viol_cnt - vbase);
        end
        total++;
        if (acc_cnt - abase !== 2) begin
            bad++; $display("FAIL bp_words got=%0d want=2", acc_cnt - abase);
        end
        total++;
        if (seq_from(base) !== 10'h3A5 || pulse_cnt - base !== 10) begin
            bad++; $display("FAIL bp_head_seq got=%h/%0d want=3a5/10", seq_from(base), pulse_cnt - base);
        end
        base = pulse_cnt;
        start_seq(1'b0);
        send_word(8'hA5);
        repeat (12) @(negedge prog_clk);
        total++;
        if ({pulse_cnt - base == 8, chain_clk_en, word_ready} !== 3'b101) begin
            bad++; $display("FAIL gap_stall got=pulses%0d en%b rdy%b want=pulses8 en0 rdy1",
                            pulse_cnt - base, chain_clk_en, word_ready);
        end
        send_word(8'h03);
        wait_done("gap");
        total++;
        if (pulse_cnt - base !== 10) begin
            bad++; $display("FAIL gap_pulses got=%0d want=10", pulse_cnt - base);
        end
    endtask

    task automatic test_abort_reset;
        int base = pulse_cnt;
        int t = 0;
        start_seq(1'b0);
        send_word(8'hA5);
        while (pulse_cnt - base < 4 && t < 50) begin @(negedge prog_clk); t++; end
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        total++;
        if ({chain_clk_en, ccff_head, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL abort_idle got=%b want=0000", {chain_clk_en, ccff_head, busy, done});
        end
        repeat (3) @(negedge prog_clk);
        total++;
        if (pulse_cnt - base !== 5 || word_ready !== 1'b0) begin
            bad++; $display("FAIL abort_pulses got=%0d rdy%b want=5 rdy0", pulse_cnt - base, word_ready);
        end
        start_seq(1'b1);
        send_word(8'hA5);
        send_word(8'h03);
        send_word(8'hA5);
        repeat (3) @(negedge prog_clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_verify_busy got=%b want=1", busy);
        end
        #2 prog_reset_n = 1'b0;
        #1;
        total++;
        if ({word_ready, ccff_head, chain_clk_en, busy, done, error, err_bit_idx} !== 14'd0) begin
            bad++; $display("FAIL rst_async got=%b want=0",
                            {word_ready, ccff_head, chain_clk_en, busy, done, error, err_bit_idx});
        end
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        base = pulse_cnt;
        start_seq(1'b0);
        send_word(8'hA5);
        send_word(8'h03);
        wait_done("post_rst");
        total++;
        if (seq_from(base) !== 10'h3A5 || pulse_cnt - base !== 10 || error !== 1'b0) begin
            bad++; $display("FAIL post_rst_load got=%h/%0d/err%b want=3a5/10/err0",
                            seq_from(base), pulse_cnt - base, error);
        end
    endtask

    initial begin
        prog_reset_n = 1'b0;
        start = 1'b0;
        verify_en = 1'b0;
        abort = 1'b0;
        word_data = 8'h00;
        word_valid = 1'b0;
        @(negedge prog_clk);
        test_reset();
        test_load_only();
        test_verify_ok();
        test_verify_fault();
        test_restart();
        test_backpressure();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
